// File: rtl/mem_ctrl.sv
// LC-3b memory controller: accepts an FSM memory request, waits a fixed
// latency, commits the access to a word RAM and pulses R for one cycle.
module mem_ctrl #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        data_size,
  input  logic [15:0] mar,
  input  logic [15:0] mdr,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        R,
  output logic [15:0] mem_rdata,
  output logic        busy
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0]   addr_q, addr_d;
  logic [15:0]   mdr_q, mdr_d;
  logic          rw_q, rw_d;
  logic          ds_q, ds_d;
  logic          r_q, r_d;
  logic          busy_q, busy_d;
  logic [15:0]   rdata_q, rdata_d;

  logic [15:0]   mem [MEM_WORDS];
  logic [AW-1:0] widx;
  logic [15:0]   cur_word, wr_word;
  logic          commit, ld_ok;
  logic          unused_addr_bits;

  // Only the bits that select a word and a byte lane are ever used.
  assign unused_addr_bits = ^{mar[15:AW+1], ld_addr[15:AW]};

  assign widx     = addr_q[AW:1];
  assign cur_word = mem[widx];
  assign commit   = (state_q == WAIT) && (cnt_q == '0);
  assign ld_ok    = (state_q == IDLE) && !mio_en && ld_en;

  always_comb begin
    wr_word = mdr_q;
    if (!ds_q) begin
      if (addr_q[0]) wr_word = {mdr_q[7:0], cur_word[7:0]};
      else           wr_word = {cur_word[15:8], mdr_q[7:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    mdr_d   = mdr_q;
    rw_d    = rw_q;
    ds_d    = ds_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mio_en) begin
          addr_d  = mar[AW:0];
          mdr_d   = mdr;
          rw_d    = r_w;
          ds_d    = data_size;
          cnt_d   = CW'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = READY;
          if (!rw_q) rdata_d = cur_word;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      READY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so R lines up with READY.
    r_d    = (state_d == READY);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      mdr_q   <= '0;
      rw_q    <= 1'b0;
      ds_q    <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mdr_q   <= mdr_d;
      rw_q    <= rw_d;
      ds_q    <= ds_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM is not reset; an async reset drops state to IDLE so an aborted write never commits.
  always_ff @(posedge clk) begin
    if (commit && rw_q) mem[widx] <= wr_word;
    else if (ld_ok)     mem[ld_addr[AW-1:0]] <= ld_data;
  end

  assign R         = r_q;
  assign busy      = busy_q;
  assign mem_rdata = rdata_q;

endmodule
